spi_master_mode: RTL and testbench

//  Parametrised full-duplex SPI master, successor to the single-mode transmitter.

---
 rtl/spi_master_mode.sv | 191 +++++++++++++++++++
 tb/tb_spi_master_mode.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_mode.sv
// Full-duplex SPI master: per-transfer CPOL/CPHA, N chip selects, MSB/LSB
// ordering, ready/valid word intake and a one-cycle rx_valid result pulse.
module spi_master_mode #(
    parameter int unsigned P_DATA_WIDTH = 8,
    parameter int unsigned P_CLK_DIV    = 2,
    parameter int unsigned P_CS_POLAR   = 0,
    parameter int unsigned P_NUM_CS     = 1,
    parameter int unsigned P_MSB_FIRST  = 1,
    localparam int unsigned L_SEL_W = (P_NUM_CS > 1) ? $clog2(P_NUM_CS) : 1
) (
    input  logic                    clk_100,
    input  logic                    a_rst_n,
    input  logic                    s_rst,
    input  logic                    valid,
    input  logic [P_DATA_WIDTH-1:0] data,
    input  logic [L_SEL_W-1:0]      cs_sel,
    input  logic                    cpol,
    input  logic                    cpha,
    output logic                    ready,
    input  logic                    MISO,
    output logic                    MOSI,
    output logic                    SCK,
    output logic [P_NUM_CS-1:0]     CS,
    output logic                    rx_valid,
    output logic [P_DATA_WIDTH-1:0] rx_data
);

    localparam int unsigned L_W      = P_DATA_WIDTH;
    localparam int unsigned L_DIV_W  = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;
    localparam int unsigned L_EDGE_W = $clog2(2 * P_DATA_WIDTH);

    localparam logic [L_DIV_W-1:0]  L_DIV_LAST  = L_DIV_W'(P_CLK_DIV - 1);
    localparam logic [L_EDGE_W-1:0] L_EDGE_LAST = L_EDGE_W'(2 * P_DATA_WIDTH - 1);
    localparam logic                L_CS_ACT    = (P_CS_POLAR != 0);
    localparam logic [P_NUM_CS-1:0] L_CS_IDLE   = {P_NUM_CS{~L_CS_ACT}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD
    } state_t;

    state_t              state;
    logic [L_DIV_W-1:0]  div_cnt;
    logic [L_EDGE_W-1:0] edge_cnt;
    logic [L_W-1:0]      tx_shift;
    logic [L_W-1:0]      rx_shift;
    logic                cpha_q;

    logic [P_NUM_CS-1:0] cs_vec;
    logic                data_first;
    logic [L_W-1:0]      data_rest;
    logic                tx_bit;
    logic [L_W-1:0]      tx_rest;
    logic [L_W-1:0]      rx_next;
    logic                div_done;
    logic                last_edge;
    logic                sample_edge;

    // Chip-select pattern for the requested slave; out-of-range index selects nothing
    always_comb begin
        cs_vec = L_CS_IDLE;
        for (int unsigned i = 0; i < P_NUM_CS; i++) begin
            if (32'(cs_sel) == i) begin
                cs_vec[i] = L_CS_ACT;
            end
        end
    end

    // Bit-order dependent serialiser/deserialiser taps
    always_comb begin
        if (P_MSB_FIRST != 0) begin
            data_first = data[L_W-1];
            data_rest  = {data[L_W-2:0], 1'b0};
            tx_bit     = tx_shift[L_W-1];
            tx_rest    = {tx_shift[L_W-2:0], 1'b0};
            rx_next    = {rx_shift[L_W-2:0], MISO};
        end else begin
            data_first = data[0];
            data_rest  = {1'b0, data[L_W-1:1]};
            tx_bit     = tx_shift[0];
            tx_rest    = {1'b0, tx_shift[L_W-1:1]};
            rx_next    = {MISO, rx_shift[L_W-1:1]};
        end
    end

    // Even edge index is a leading edge; CPHA picks which edge type samples MISO
    always_comb begin
        div_done    = (div_cnt == L_DIV_LAST);
        last_edge   = (edge_cnt == L_EDGE_LAST);
        sample_edge = (edge_cnt[0] == cpha_q);
    end

    // Transfer sequencer with registered SPI pins and handshake outputs
    always_ff @(posedge clk_100 or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            cpha_q   <= 1'b0;
            ready    <= 1'b1;
            MOSI     <= 1'b0;
            SCK      <= 1'b0;
            CS       <= L_CS_IDLE;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else if (s_rst) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            cpha_q   <= 1'b0;
            ready    <= 1'b1;
            MOSI     <= 1'b0;
            SCK      <= 1'b0;
            CS       <= L_CS_IDLE;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        cpha_q   <= cpha;
                        SCK      <= cpol;
                        CS       <= cs_vec;
                        rx_shift <= '0;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        ready    <= 1'b0;
                        state    <= S_SETUP;
                        if (!cpha) begin
                            MOSI     <= data_first;
                            tx_shift <= data_rest;
                        end else begin
                            tx_shift <= data;
                        end
                    end
                end
                S_SETUP: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= S_XFER;
                    end else begin
                        div_cnt <= div_cnt + L_DIV_W'(1);
                    end
                end
                S_XFER: begin
                    if (div_done) begin
                        div_cnt  <= '0;
                        SCK      <= ~SCK;
                        edge_cnt <= edge_cnt + L_EDGE_W'(1);
                        if (sample_edge) begin
                            rx_shift <= rx_next;
                        end else if (!last_edge) begin
                            MOSI     <= tx_bit;
                            tx_shift <= tx_rest;
                        end
                        if (last_edge) begin
                            edge_cnt <= '0;
                            state    <= S_HOLD;
                        end
                    end else begin
                        div_cnt <= div_cnt + L_DIV_W'(1);
                    end
                end
                S_HOLD: begin
                    if (div_done) begin
                        div_cnt  <= '0;
                        CS       <= L_CS_IDLE;
                        MOSI     <= 1'b0;
                        rx_valid <= 1'b1;
                        rx_data  <= rx_shift;
                        ready    <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        div_cnt <= div_cnt + L_DIV_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_mode.sv
// Bench for spi_master_mode: two instances run in lockstep (MSB/4 CS/active-low
// and LSB/3 CS/active-high) against an SPI slave model and transfer statistics.
module tb_spi_master_mode;

    localparam int unsigned W        = 8;
    localparam int unsigned DIV      = 2;
    localparam int          XFER_CYC = (2 * W + 2) * DIV;
    localparam int          WIN      = 45;

    logic       clk = 1'b0;
    logic       a_rst_n, s_rst, valid, cpol, cpha;
    logic [7:0] data;
    logic [1:0] cs_sel;

    logic       ready_a, mosi_a, sck_a, rxv_a, miso_a;
    logic [3:0] cs_a;
    logic [7:0] rxd_a;
    logic       ready_b, mosi_b, sck_b, rxv_b, miso_b;
    logic [2:0] cs_b;
    logic [7:0] rxd_b;

    logic       lb_mode = 1'b0;
    logic [7:0] sword [2];
    logic       exp_pol = 1'b0, exp_pha = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    // slave model state
    logic       s_bit [2];
    logic       s_pol [2];
    logic       s_pha [2];
    logic [7:0] s_word [2];
    logic [7:0] s_rx [2];
    logic       s_first [2];
    int         s_tx [2];
    int         s_nsamp [2];
    logic       prv_rdy [2];
    logic       prv_sck [2];

    // per-transfer observations
    int         r_low [2], r_rxv [2], r_at [2], r_on [2], r_bad [2], r_tog [2];
    logic [7:0] r_rxd [2];
    logic       r_rdy [2], r_mosi [2], r_sck1 [2], r_sckn [2];

    always #5 clk = ~clk;

    assign miso_a = lb_mode ? mosi_a : s_bit[0];
    assign miso_b = lb_mode ? mosi_b : s_bit[1];

    spi_master_mode #(.P_DATA_WIDTH(W), .P_CLK_DIV(DIV), .P_CS_POLAR(0),
                      .P_NUM_CS(4), .P_MSB_FIRST(1)) dut_a (
        .clk_100(clk), .a_rst_n(a_rst_n), .s_rst(s_rst), .valid(valid),
        .data(data), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .ready(ready_a),
        .MISO(miso_a), .MOSI(mosi_a), .SCK(sck_a), .CS(cs_a),
        .rx_valid(rxv_a), .rx_data(rxd_a));

    spi_master_mode #(.P_DATA_WIDTH(W), .P_CLK_DIV(DIV), .P_CS_POLAR(1),
                      .P_NUM_CS(3), .P_MSB_FIRST(0)) dut_b (
        .clk_100(clk), .a_rst_n(a_rst_n), .s_rst(s_rst), .valid(valid),
        .data(data), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .ready(ready_b),
        .MISO(miso_b), .MOSI(mosi_b), .SCK(sck_b), .CS(cs_b),
        .rx_valid(rxv_b), .rx_data(rxd_b));

    function automatic logic is_msb(input int d);
        return (d == 0);
    endfunction
    function automatic logic rdy(input int d);
        return (d == 0) ? ready_a : ready_b;
    endfunction
    function automatic logic sck(input int d);
        return (d == 0) ? sck_a : sck_b;
    endfunction
    function automatic logic mosi(input int d);
        return (d == 0) ? mosi_a : mosi_b;
    endfunction
    function automatic logic rxv(input int d);
        return (d == 0) ? rxv_a : rxv_b;
    endfunction
    function automatic logic [7:0] rxd(input int d);
        return (d == 0) ? rxd_a : rxd_b;
    endfunction
    // active lines normalised to 1 = asserted
    function automatic logic [3:0] cs_act(input int d);
        return (d == 0) ? ~cs_a : {1'b0, cs_b};
    endfunction
    function automatic logic in_range(input int d, input logic [1:0] sel);
        return (d == 0) ? 1'b1 : (sel < 2'd3);
    endfunction
    // i-th bit on the wire for a word in the given order
    function automatic logic wire_bit(input logic [7:0] w, input int i, input logic msb);
        return msb ? w[7-i] : w[i];
    endfunction

    // SPI slave: shifts its word out on the drive edge, captures MOSI on the sample edge
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic lead;
            if (prv_rdy[d] === 1'b1 && rdy(d) === 1'b0) begin
                s_pol[d]   = exp_pol;
                s_pha[d]   = exp_pha;
                s_word[d]  = sword[d];
                s_tx[d]    = 0;
                s_rx[d]    = 8'h00;
                s_nsamp[d] = 0;
                s_first[d] = 1'b0;
                if (!exp_pha) begin
                    s_bit[d] = wire_bit(sword[d], 0, is_msb(d));
                    s_tx[d]  = 1;
                end
            end else if (rdy(d) === 1'b0 && sck(d) !== prv_sck[d]) begin
                lead = (sck(d) != s_pol[d]);
                if (lead != s_pha[d]) begin
                    if (s_nsamp[d] < 8) begin
                        if (is_msb(d)) s_rx[d][7 - s_nsamp[d]] = mosi(d);
                        else           s_rx[d][s_nsamp[d]]     = mosi(d);
                        if (s_nsamp[d] == 0) s_first[d] = mosi(d);
                    end
                    s_nsamp[d]++;
                end else begin
                    if (s_tx[d] < 8) s_bit[d] = wire_bit(s_word[d], s_tx[d], is_msb(d));
                    s_tx[d]++;
                end
            end
            prv_rdy[d] = rdy(d);
            prv_sck[d] = sck(d);
        end
    end

    // Issue one word and collect per-instance statistics over a fixed window
    task automatic do_xfer(input logic [7:0] d, input logic [1:0] sel, input logic pol,
                           input logic pha, input logic lb, input logic [7:0] sw0,
                           input logic [7:0] sw1);
        logic ps [2];
        @(posedge clk); #1;
        data = d; cs_sel = sel; cpol = pol; cpha = pha;
        exp_pol = pol; exp_pha = pha; lb_mode = lb;
        sword[0] = sw0; sword[1] = sw1; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        data = 8'($urandom); cs_sel = 2'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
        for (int dd = 0; dd < 2; dd++) begin
            r_low[dd] = 0; r_rxv[dd] = 0; r_at[dd] = -1; r_on[dd] = 0; r_bad[dd] = 0;
            r_tog[dd] = 0; r_rxd[dd] = 8'hxx; r_rdy[dd] = 1'bx; r_mosi[dd] = 1'bx;
        end
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            for (int dd = 0; dd < 2; dd++) begin
                if (rdy(dd) !== 1'b1) r_low[dd]++;
                if (rxv(dd) === 1'b1) begin
                    r_rxv[dd]++;
                    r_at[dd]   = k;
                    r_rxd[dd]  = rxd(dd);
                    r_rdy[dd]  = rdy(dd);
                    r_mosi[dd] = mosi(dd);
                end
                if (cs_act(dd) !== 4'b0000) begin
                    if (in_range(dd, sel) && cs_act(dd) === (4'b0001 << sel)) r_on[dd]++;
                    else r_bad[dd]++;
                end
                if (k == 1) r_sck1[dd] = sck(dd);
                else if (sck(dd) !== ps[dd]) r_tog[dd]++;
                ps[dd] = sck(dd);
                if (k == WIN) r_sckn[dd] = sck(dd);
            end
        end
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; s_rst = 1'b0; valid = 1'b0;
        data = 8'h00; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0;
        #12;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if ({rdy(d), mosi(d), sck(d), rxv(d)} !== 4'b1000)
                $display("FAIL reset_pins dut%0d: got rdy/mosi/sck/rxv=%b want 1000", d,
                         {rdy(d), mosi(d), sck(d), rxv(d)});
            else n_pass++;
            n_total++;
            if (cs_act(d) !== 4'b0000)
                $display("FAIL reset_cs dut%0d: got active=%b want 0000", d, cs_act(d));
            else n_pass++;
            n_total++;
            if (rxd(d) !== 8'h00)
                $display("FAIL reset_rx_data dut%0d: got %h want 00", d, rxd(d));
            else n_pass++;
        end
        @(negedge clk);
        a_rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0_loopback();
        do_xfer(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (r_rxd[d] !== 8'hA5)
                $display("FAIL m0_rx_data dut%0d: got %h want a5", d, r_rxd[d]);
            else n_pass++;
            n_total++;
            if (s_rx[d] !== 8'hA5)
                $display("FAIL m0_mosi_bits dut%0d: got %h want a5", d, s_rx[d]);
            else n_pass++;
            n_total++;
            if (r_at[d] != XFER_CYC + 1 || r_rxv[d] != 1)
                $display("FAIL m0_latency dut%0d: got at=%0d n=%0d want at=%0d n=1",
                         d, r_at[d], r_rxv[d], XFER_CYC + 1);
            else n_pass++;
            n_total++;
            if (r_low[d] != XFER_CYC)
                $display("FAIL m0_ready_low dut%0d: got %0d want %0d", d, r_low[d], XFER_CYC);
            else n_pass++;
        end
    endtask

    task automatic test_mode3();
        do_xfer(8'h3C, 2'd0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (r_rxd[d] !== 8'hFF)
                $display("FAIL m3_rx_data dut%0d: got %h want ff", d, r_rxd[d]);
            else n_pass++;
            n_total++;
            if ({r_sck1[d], r_sckn[d]} !== 2'b11)
                $display("FAIL m3_sck_idle dut%0d: got start/end=%b want 11", d,
                         {r_sck1[d], r_sckn[d]});
            else n_pass++;
            n_total++;
            if (r_tog[d] != 2 * W)
                $display("FAIL m3_sck_edges dut%0d: got %0d want %0d", d, r_tog[d], 2 * W);
            else n_pass++;
            n_total++;
            if (s_rx[d] !== 8'h3C || s_nsamp[d] != 8)
                $display("FAIL m3_mosi_bits dut%0d: got %h/%0d want 3c/8", d, s_rx[d], s_nsamp[d]);
            else n_pass++;
        end
    endtask

    task automatic test_cs_select();
        logic [1:0] sels [2] = '{2'd2, 2'd3};
        for (int i = 0; i < 2; i++) begin
            logic [7:0] sw0, sw1;
            sw0 = 8'($urandom); sw1 = 8'($urandom);
            do_xfer(8'($urandom), sels[i], 1'b0, 1'b0, 1'b0, sw0, sw1);
            for (int d = 0; d < 2; d++) begin
                int exp_on;
                exp_on = in_range(d, sels[i]) ? XFER_CYC : 0;
                n_total++;
                if (r_on[d] != exp_on || r_bad[d] != 0)
                    $display("FAIL cs_select dut%0d sel=%0d: got on=%0d bad=%0d want on=%0d bad=0",
                             d, sels[i], r_on[d], r_bad[d], exp_on);
                else n_pass++;
                n_total++;
                if (r_rxv[d] != 1 || r_rxd[d] !== ((d == 0) ? sw0 : sw1))
                    $display("FAIL cs_rx dut%0d sel=%0d: got n=%0d data=%h want n=1 data=%h",
                             d, sels[i], r_rxv[d], r_rxd[d], (d == 0) ? sw0 : sw1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_bit_order();
        do_xfer(8'h01, 2'd1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (s_first[d] !== (d == 1))
                $display("FAIL order_first_bit dut%0d: got %b want %b", d, s_first[d], d == 1);
            else n_pass++;
            n_total++;
            if (r_rxd[d] !== 8'h01)
                $display("FAIL order_rx_data dut%0d: got %h want 01", d, r_rxd[d]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            logic [7:0] d8, sw0, sw1;
            logic [1:0] sel;
            logic pol, pha, lb;
            d8 = 8'($urandom); sw0 = 8'($urandom); sw1 = 8'($urandom);
            sel = 2'($urandom); pol = 1'($urandom); pha = 1'($urandom);
            lb = ($urandom_range(0, 3) == 0);
            do_xfer(d8, sel, pol, pha, lb, sw0, sw1);
            for (int d = 0; d < 2; d++) begin
                logic [7:0] exp_rx;
                exp_rx = lb ? d8 : ((d == 0) ? sw0 : sw1);
                n_total++;
                if (r_rxd[d] !== exp_rx || r_rxv[d] != 1 || r_at[d] != XFER_CYC + 1)
                    $display("FAIL rnd_rx t%0d dut%0d: got %h n=%0d at=%0d want %h n=1 at=%0d",
                             t, d, r_rxd[d], r_rxv[d], r_at[d], exp_rx, XFER_CYC + 1);
                else n_pass++;
                n_total++;
                if (s_rx[d] !== d8 || s_nsamp[d] != 8)
                    $display("FAIL rnd_mosi t%0d dut%0d: got %h/%0d want %h/8",
                             t, d, s_rx[d], s_nsamp[d], d8);
                else n_pass++;
                n_total++;
                if (r_tog[d] != 2 * W || r_sck1[d] !== pol || r_sckn[d] !== pol)
                    $display("FAIL rnd_sck t%0d dut%0d: got edges=%0d start=%b end=%b want %0d/%b/%b",
                             t, d, r_tog[d], r_sck1[d], r_sckn[d], 2 * W, pol, pol);
                else n_pass++;
                n_total++;
                if (r_on[d] != (in_range(d, sel) ? XFER_CYC : 0) || r_bad[d] != 0 ||
                    r_low[d] != XFER_CYC)
                    $display("FAIL rnd_cs t%0d dut%0d sel=%0d: got on=%0d bad=%0d low=%0d",
                             t, d, sel, r_on[d], r_bad[d], r_low[d]);
                else n_pass++;
                n_total++;
                if (r_rdy[d] !== 1'b1 || r_mosi[d] !== 1'b0)
                    $display("FAIL rnd_end t%0d dut%0d: got ready=%b mosi=%b want 1/0",
                             t, d, r_rdy[d], r_mosi[d]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [80:0] act [2];
        int         r1 [2], r2 [2];
        logic [7:0] d1 [2], d2 [2];
        logic [2:0] gap;
        @(posedge clk); #1;
        data = 8'h11; cs_sel = 2'd1; cpol = 1'b0; cpha = 1'b0;
        exp_pol = 1'b0; exp_pha = 1'b0; lb_mode = 1'b1; valid = 1'b1;
        @(posedge clk); #1;
        data = 8'h22;
        for (int d = 0; d < 2; d++) begin
            r1[d] = -1; r2[d] = -1; act[d] = '0; d1[d] = 8'hxx; d2[d] = 8'hxx;
        end
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                act[d][k] = cs_act(d)[1];
                if (rxv(d) === 1'b1) begin
                    if (r1[d] < 0) begin r1[d] = k; d1[d] = rxd(d); end
                    else if (r2[d] < 0) begin r2[d] = k; d2[d] = rxd(d); end
                end
            end
            if (valid && (r1[0] == k || k == 60)) begin
                @(posedge clk); #1;
                valid = 1'b0;
            end
        end
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (r1[d] != XFER_CYC + 1 || r2[d] - r1[d] != XFER_CYC + 1)
                $display("FAIL b2b_spacing dut%0d: got r1=%0d r2=%0d want r1=%0d gap=%0d",
                         d, r1[d], r2[d], XFER_CYC + 1, XFER_CYC + 1);
            else n_pass++;
            n_total++;
            if (d1[d] !== 8'h11 || d2[d] !== 8'h22)
                $display("FAIL b2b_data dut%0d: got %h,%h want 11,22", d, d1[d], d2[d]);
            else n_pass++;
            gap = (r1[d] >= 2 && r1[d] <= 79) ?
                  {act[d][r1[d] - 1], act[d][r1[d]], act[d][r1[d] + 1]} : 3'b000;
            n_total++;
            if (gap !== 3'b101)
                $display("FAIL b2b_cs_gap dut%0d: got %b want 101", d, gap);
            else n_pass++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic start_word(input logic [7:0] d8);
        @(posedge clk); #1;
        data = d8; cs_sel = 2'd0; cpol = 1'b1; cpha = 1'b0;
        exp_pol = 1'b1; exp_pha = 1'b0; lb_mode = 1'b0; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (11) @(negedge clk);
    endtask

    task automatic test_sync_reset();
        int n_rxv;
        start_word(8'hFF);
        s_rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if ({rdy(d), sck(d), mosi(d), rxv(d)} !== 4'b1000 || cs_act(d) !== 4'b0000)
                $display("FAIL srst_pins dut%0d: got rdy/sck/mosi/rxv=%b cs=%b want 1000/0000",
                         d, {rdy(d), sck(d), mosi(d), rxv(d)}, cs_act(d));
            else n_pass++;
        end
        s_rst = 1'b0;
        n_rxv = 0;
        for (int k = 0; k < WIN; k++) begin
            @(negedge clk);
            if (rxv_a === 1'b1 || rxv_b === 1'b1) n_rxv++;
        end
        n_total++;
        if (n_rxv != 0) $display("FAIL srst_no_rx_valid: got %0d pulses want 0", n_rxv);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int n_rxv;
        start_word(8'hFF);
        #1;
        a_rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if ({rdy(d), sck(d), mosi(d), rxv(d)} !== 4'b1000 || cs_act(d) !== 4'b0000)
                $display("FAIL arst_pins dut%0d: got rdy/sck/mosi/rxv=%b cs=%b want 1000/0000",
                         d, {rdy(d), sck(d), mosi(d), rxv(d)}, cs_act(d));
            else n_pass++;
        end
        @(negedge clk);
        a_rst_n = 1'b1;
        n_rxv = 0;
        for (int k = 0; k < WIN; k++) begin
            @(negedge clk);
            if (rxv_a === 1'b1 || rxv_b === 1'b1) n_rxv++;
        end
        n_total++;
        if (n_rxv != 0) $display("FAIL arst_no_rx_valid: got %0d pulses want 0", n_rxv);
        else n_pass++;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            s_bit[d] = 1'b0; s_pol[d] = 1'b0; s_pha[d] = 1'b0; s_word[d] = 8'h00;
            s_rx[d] = 8'h00; s_first[d] = 1'b0; s_tx[d] = 0; s_nsamp[d] = 0;
            prv_rdy[d] = 1'b1; prv_sck[d] = 1'b0; sword[d] = 8'h00;
        end
        test_reset();
        test_mode0_loopback();
        test_mode3();
        test_cs_select();
        test_bit_order();
        test_random();
        test_back_to_back();
        test_sync_reset();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
